// File: rtl/hc595_pkg.sv
// Shared types and constants for the 74x595 chain driver.
package hc595_pkg;

  localparam int BYTE_W = 8;
  localparam int DIV_W  = 8;

  typedef enum logic [2:0] {
    INIT_CLR = 3'd0,
    INIT_LAT = 3'd1,
    IDLE     = 3'd2,
    SHIFT_LO = 3'd3,
    SHIFT_HI = 3'd4,
    LATCH    = 3'd5
  } hc595_state_t;

endpackage

// File: rtl/hc595_pwm.sv
// Output-enable dimmer: free-running 8-bit counter compared against the brightness
// level. Only built when HC595_PWM_EN is defined.
`ifdef HC595_PWM_EN
module hc595_pwm
  import hc595_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] bright,
  output logic              dark
);

  logic [BYTE_W-1:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + 8'd1;
  end

  assign dark = (pwm_cnt >= bright);

endmodule
`endif

// File: rtl/hc595_chain_driver.sv
// Serial loader for a chain of cascaded 595 shift/latch registers, MSB first.
// Define HC595_PWM_EN to dim the chain through G using the bright input.
module hc595_chain_driver
  import hc595_pkg::*;
#(
  parameter int CHAIN = 1,
  parameter int DIV   = 2
)
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [8*CHAIN-1:0] in_data,
  output logic               in_ready,
  output logic               done,
  input  logic [7:0]         bright,
  output logic               SI,
  output logic               SCK,
  output logic               RCK,
  output logic               SCLR,
  output logic               G,
  output logic [2:0]         dbg_state
);

  localparam int W  = BYTE_W * CHAIN;
  localparam int CW = $clog2(W + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  // Handshake: a word transfers on any rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE (including the done cycle), in_data is ignored otherwise.

  hc595_state_t     state, nxt;
  logic [DIV_W-1:0] cnt, nxt_cnt;
  logic [W-1:0]     shreg, nxt_shreg;
  logic [CW-1:0]    bits, nxt_bits;
  logic             last, nxt_done, nxt_init, dark;

`ifdef HC595_PWM_EN
  hc595_pwm u_pwm (
    .clk    (clk),
    .rst_n  (rst_n),
    .bright (bright),
    .dark   (dark)
  );
`else
  logic unused_bright;
  assign unused_bright = ^bright;
  assign dark          = 1'b0;
`endif

  assign last      = (cnt == DIV_LAST);
  assign dbg_state = state;

  always_comb begin
    nxt       = state;
    nxt_cnt   = cnt + 8'd1;
    nxt_shreg = shreg;
    nxt_bits  = bits;
    nxt_done  = 1'b0;
    case (state)
      INIT_CLR: if (last) nxt = INIT_LAT;
      INIT_LAT: if (last) nxt = IDLE;
      IDLE: begin
        if (in_valid && in_ready) begin
          nxt       = SHIFT_LO;
          nxt_shreg = in_data;
          nxt_bits  = CW'(W);
        end
      end
      SHIFT_LO: if (last) nxt = SHIFT_HI;
      SHIFT_HI: begin
        if (last) begin
          nxt_shreg = shreg << 1;
          nxt_bits  = bits - CW'(1);
          nxt       = (bits == CW'(1)) ? LATCH : SHIFT_LO;
        end
      end
      LATCH: begin
        if (last) begin
          nxt      = IDLE;
          nxt_done = 1'b1;
        end
      end
      default: nxt = INIT_CLR;
    endcase
    // Every phase starts its half-period count from zero; IDLE never counts.
    if (nxt != state || state == IDLE) nxt_cnt = '0;
    nxt_init = (nxt == INIT_CLR) || (nxt == INIT_LAT);
  end

  // Pins are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= INIT_CLR;
      cnt      <= '0;
      shreg    <= '0;
      bits     <= '0;
      SI       <= 1'b0;
      SCK      <= 1'b0;
      RCK      <= 1'b0;
      SCLR     <= 1'b0;
      G        <= 1'b1;
      in_ready <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= nxt;
      cnt      <= nxt_cnt;
      shreg    <= nxt_shreg;
      bits     <= nxt_bits;
      SI       <= (nxt == SHIFT_LO) ? nxt_shreg[W-1] : SI;
      SCK      <= (nxt == SHIFT_HI);
      RCK      <= (nxt == INIT_LAT) || (nxt == LATCH);
      SCLR     <= (nxt != INIT_CLR);
      G        <= nxt_init | dark;
      in_ready <= (nxt == IDLE);
      done     <= nxt_done;
    end
  end

endmodule

// File: tb/tb_hc595_chain_driver.sv
// Directed bench for hc595_chain_driver: one 1-device and one 2-device chain,
// each observed through a behavioural 595 model.
module tb_hc595_chain_driver;

  logic        clk;
  logic        rst_n;
  logic [7:0]  bright;

  logic        v1, rdy1, done1, si1, sck1, rck1, sclr1, g1;
  logic [7:0]  d1;
  logic [2:0]  st1;
  logic        v2, rdy2, done2, si2, sck2, rck2, sclr2, g2;
  logic [15:0] d2;
  logic [2:0]  st2;

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  hc595_chain_driver #(.CHAIN(1), .DIV(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_data(d1), .in_ready(rdy1),
    .done(done1), .bright(bright), .SI(si1), .SCK(sck1), .RCK(rck1),
    .SCLR(sclr1), .G(g1), .dbg_state(st1)
  );

  hc595_chain_driver #(.CHAIN(2), .DIV(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_data(d2), .in_ready(rdy2),
    .done(done2), .bright(bright), .SI(si2), .SCK(sck2), .RCK(rck2),
    .SCLR(sclr2), .G(g2), .dbg_state(st2)
  );

  // ---------------- 595 chain models ----------------
  logic [7:0]  sr1, q1;
  logic [15:0] sr2, q2;
  int          rises1 = 0;
  int          rises2 = 0;
  logic [0:0]  got_q[$];
  logic [0:0]  exp_q[$];

  always @(posedge sck1 or negedge sclr1) begin
    if (!sclr1) sr1 <= '0;
    else begin
      sr1    <= {sr1[6:0], si1};
      rises1 <= rises1 + 1;
      got_q.push_back(si1);
    end
  end
  always @(posedge rck1) q1 <= sr1;

  always @(posedge sck2 or negedge sclr2) begin
    if (!sclr2) sr2 <= '0;
    else begin
      sr2    <= {sr2[14:0], si2};
      rises2 <= rises2 + 1;
    end
  end
  always @(posedge rck2) q2 <= sr2;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done1(output int lat, output int rhi);
    lat = 0;
    rhi = 0;
    while (done1 !== 1'b1 && lat < 200) begin
      tick();
      lat++;
      if (rck1) rhi++;
    end
  endtask

  task automatic wait_done2(output int lat);
    lat = 0;
    while (done2 !== 1'b1 && lat < 300) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_init(input string tag);
    tick();
    check({tag, "_sclr_lo"}, sclr1, 1'b0);
    check({tag, "_rck_lo"}, rck1, 1'b0);
    tick();
    check({tag, "_sclr_hi"}, sclr1, 1'b1);
    check({tag, "_rck_hi"}, rck1, 1'b1);
    check({tag, "_g_init"}, g1, 1'b1);
    tick();
    check({tag, "_rck_hi2"}, rck1, 1'b1);
    check({tag, "_rdy_lo"}, rdy1, 1'b0);
    tick();
    check({tag, "_rdy_hi"}, rdy1, 1'b1);
    check({tag, "_rck_end"}, rck1, 1'b0);
    check({tag, "_g_on"}, g1, 1'b0);
    check({tag, "_q_zero"}, q1, 8'h00);
  endtask

  // ---------------- directed sequence ----------------
  int lat, rhi, base, r0, low;
  logic [7:0] word;

  initial begin
    rst_n  = 1'b0;
    bright = 8'd64;
    v1 = 1'b0; d1 = '0;
    v2 = 1'b0; d2 = '0;
    repeat (3) tick();

    check("rst_si", si1, 1'b0);
    check("rst_sck", sck1, 1'b0);
    check("rst_rck", rck1, 1'b0);
    check("rst_sclr", sclr1, 1'b0);
    check("rst_g", g1, 1'b1);
    check("rst_ready", rdy1, 1'b0);
    check("rst_done", done1, 1'b0);
    check("rst_state", st1, 3'd0);
    check("rst_g2", g2, 1'b1);

    rst_n = 1'b1;
    check_init("init");
    check("init_rdy2", rdy2, 1'b1);

    // single word 8'hA5
    base = got_q.size();
    r0   = rises1;
    v1 = 1'b1; d1 = 8'hA5;
    tick();
    check("a5_accept_rdy", rdy1, 1'b0);
    check("a5_first_si", si1, 1'b1);
    v1 = 1'b0; d1 = 8'h00;
    wait_done1(lat, rhi);
    check("a5_latency", lat, 34);
    check("a5_rck_width", rhi, 2);
    check("a5_q", q1, 8'hA5);
    check("a5_rises", rises1 - r0, 8);
    check("a5_done_rdy", rdy1, 1'b1);
    word = 8'hA5;
    for (int i = 7; i >= 0; i--) exp_q.push_back(word[i]);
    for (int i = 0; i < 8; i++) check("a5_si_bit", got_q[base + i], exp_q.pop_front());
    tick();
    check("a5_done_pulse", done1, 1'b0);

    // two-device chain, 16'h1234
    r0 = rises2;
    v2 = 1'b1; d2 = 16'h1234;
    tick();
    v2 = 1'b0;
    wait_done2(lat);
    check("c2_latency", lat, 66);
    check("c2_dev0", q2[7:0], 8'h34);
    check("c2_dev1", q2[15:8], 8'h12);
    check("c2_rises", rises2 - r0, 16);

    // back-to-back with in_valid held high
    v1 = 1'b1; d1 = 8'hFF;
    tick();
    check("b2b_first_si", si1, 1'b1);
    d1 = 8'h00;
    wait_done1(lat, rhi);
    check("b2b_lat1", lat, 34);
    check("b2b_q1", q1, 8'hFF);
    check("b2b_rdy_done", rdy1, 1'b1);
    tick();
    check("b2b_accept", rdy1, 1'b0);
    check("b2b_second_si", si1, 1'b0);
    v1 = 1'b0;
    tick();
    check("b2b_sck_lo", sck1, 1'b0);
    tick();
    check("b2b_sck_hi", sck1, 1'b1);
    wait_done1(lat, rhi);
    check("b2b_lat2", lat, 32);
    check("b2b_q2", q1, 8'h00);

    // reset during bit 3 (SHIFT_HI half)
    v1 = 1'b1; d1 = 8'h5A;
    tick();
    v1 = 1'b0;
    repeat (14) tick();
    check("abort_pre_sck", sck1, 1'b1);
    check("abort_pre_state", st1, 3'd4);
    rst_n = 1'b0;
    tick();
    check("abort_sck", sck1, 1'b0);
    check("abort_rck", rck1, 1'b0);
    check("abort_sclr", sclr1, 1'b0);
    check("abort_g", g1, 1'b1);
    check("abort_rdy", rdy1, 1'b0);
    rst_n = 1'b1;
    check_init("reinit");

    // output enable behaviour
`ifdef HC595_PWM_EN
    bright = 8'd64;
    repeat (4) tick();
    low = 0;
    repeat (256) begin
      tick();
      if (!g1) low++;
    end
    check("pwm_64_low", low, 64);
    bright = 8'd0;
    repeat (4) tick();
    low = 0;
    repeat (256) begin
      tick();
      if (!g1) low++;
    end
    check("pwm_0_low", low, 0);
`else
    bright = 8'd0;
    low = 0;
    repeat (256) begin
      tick();
      if (!g1) low++;
    end
    check("g_always_on", low, 256);
`endif

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
